// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two word requesters.
// One transaction in flight at a time; reads wait RD_LATENCY cycles for mem_data_out.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_ack,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_RE,
  output logic              mem_WE,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              port_q, port_d;
  logic              last_gnt_q, last_gnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              p1_wins;
  logic              misaligned;
  logic              in_access;
  logic              in_resp;

  assign misaligned = (addr_q[1:0] != 2'b00);
  assign in_access  = (state_q == ACCESS);
  assign in_resp    = (state_q == RESP);

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    // On contention the port that did not win last time goes next.
    p1_wins    = p1_req && (!p0_req || !last_gnt_q);
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          port_d     = p1_wins;
          last_gnt_d = p1_wins;
          we_d       = p1_wins ? p1_we    : p0_we;
          addr_d     = p1_wins ? p1_addr  : p0_addr;
          wdata_d    = p1_wins ? p1_wdata : p0_wdata;
          err_d      = 1'b0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (misaligned) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = 3'(RD_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = mem_data_out;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      port_q     <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Strobes decode from registered state so reset drops them immediately.
  assign p0_gnt      = in_access && !port_q;
  assign p1_gnt      = in_access &&  port_q;
  assign p0_ack      = in_resp   && !port_q;
  assign p1_ack      = in_resp   &&  port_q;
  assign p0_err      = in_resp   && !port_q && err_q;
  assign p1_err      = in_resp   &&  port_q && err_q;
  assign mem_WE      = in_access &&  we_q && !misaligned;
  assign mem_RE      = in_access && !we_q && !misaligned;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scoreboard of expected acks, memory models at latency 1 and 3.
module tb_mem_port_arbiter;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_ack, p0_err, p1_gnt, p1_ack, p1_err;
  logic [31:0] rsp_rdata, mem_addr, mem_data_in, mem_data_out;
  logic        mem_RE, mem_WE, busy;

  logic        d3_req, d3_we;
  logic [31:0] d3_addr, d3_wdata;
  logic        d3_gnt, d3_ack, d3_err, d3_p1_gnt, d3_p1_ack, d3_p1_err;
  logic [31:0] d3_rdata, d3_mem_addr, d3_mem_data_in, d3_mem_data_out;
  logic        d3_RE, d3_WE, d3_busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_err(p1_err),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_RE(mem_RE), .mem_WE(mem_WE), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .p0_req(d3_req), .p0_we(d3_we), .p0_addr(d3_addr), .p0_wdata(d3_wdata),
    .p0_gnt(d3_gnt), .p0_ack(d3_ack), .p0_err(d3_err),
    .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
    .p1_gnt(d3_p1_gnt), .p1_ack(d3_p1_ack), .p1_err(d3_p1_err),
    .rsp_rdata(d3_rdata), .mem_addr(d3_mem_addr), .mem_data_in(d3_mem_data_in),
    .mem_data_out(d3_mem_data_out), .mem_RE(d3_RE), .mem_WE(d3_WE), .busy(d3_busy)
  );

  // Memory models: data appears RD_LATENCY cycles after the mem_RE cycle, poison otherwise.
  logic [31:0] mem_arr [0:255];
  logic [31:0] rd_pipe [0:3];
  logic [31:0] d3_arr  [0:255];
  logic [31:0] d3_pipe [0:3];
  assign mem_data_out    = rd_pipe[LAT-1];
  assign d3_mem_data_out = d3_pipe[2];

  always @(posedge clk) begin
    if (mem_WE) mem_arr[mem_addr[9:2]] <= mem_data_in;
    rd_pipe[0] <= mem_RE ? mem_arr[mem_addr[9:2]] : 32'hBAD0_BAD0;
    if (d3_WE) d3_arr[d3_mem_addr[9:2]] <= d3_mem_data_in;
    d3_pipe[0] <= d3_RE ? d3_arr[d3_mem_addr[9:2]] : 32'hBAD3_BAD3;
    for (int i = 1; i < 4; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      d3_pipe[i] <= d3_pipe[i-1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          ack_cyc;
    int          n_re;
    int          n_we;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  logic [31:0] rdata_model = '0;
  int          re_cnt = 0;
  int          we_cnt = 0;

  task automatic push(input int port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int ack_cyc);
    exp_t e;
    e.port = port; e.ack_cyc = ack_cyc; e.n_re = 0; e.n_we = 0;
    e.err  = (addr[1:0] != 2'b00);
    if (e.err) begin
      rdata_model = '0;
    end else if (we) begin
      ref_mem[int'(addr)] = wdata;
      e.n_we = 1;
    end else begin
      rdata_model = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 32'h0;
      e.n_re = 1;
    end
    e.rdata = rdata_model;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      re_cnt = 0;
      we_cnt = 0;
    end else begin
      if (mem_RE || mem_WE) check("re_we_excl", mem_RE & mem_WE, 0);
      if (p0_gnt && p1_gnt) check("dual_gnt", 1, 0);
      re_cnt += int'(mem_RE);
      we_cnt += int'(mem_WE);
      if (p0_ack || p1_ack) begin
        if (sb.size() == 0) begin
          check("spurious_ack", {p1_ack, p0_ack}, 0);
        end else begin
          e = sb.pop_front();
          check("ack_port", {p1_ack, p0_ack}, (e.port == 1) ? 2'b10 : 2'b01);
          check("ack_err", (e.port == 1) ? p1_err : p0_err, e.err);
          check("loser_err", (e.port == 1) ? p0_err : p1_err, 0);
          check("rsp_rdata", rsp_rdata, e.rdata);
          if (e.ack_cyc >= 0) check("ack_cycle", cyc, e.ack_cyc);
          check("re_pulses", re_cnt, e.n_re);
          check("we_pulses", we_cnt, e.n_we);
        end
        re_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic set_req(input int port, input logic v);
    if (port == 0) p0_req = v;
    else p1_req = v;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      check("ack_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Isolated transaction from IDLE; the driving cycle is cycle 0.
  task automatic txn(input int port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata);
    int   c;
    logic err;
    @(posedge clk); #1;
    c   = cyc;
    err = (addr[1:0] != 2'b00);
    drive(port, 1'b1, we, addr, wdata);
    push(port, we, addr, wdata, (err || we) ? c + 2 : c + 2 + LAT);
    @(negedge clk);
    @(negedge clk);
    check("gnt_cycle1", {p1_gnt, p0_gnt}, (port == 1) ? 2'b10 : 2'b01);
    check("mem_WE_c1", mem_WE, we && !err);
    check("mem_RE_c1", mem_RE, !we && !err);
    check("mem_addr_c1", mem_addr, addr);
    if (we) check("mem_data_in_c1", mem_data_in, wdata);
    set_req(port, 1'b0);
    wait_drain();
  endtask

  // Called with reset asserted: both ports request from reset, grants alternate from port 0.
  task automatic contend(input logic we, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1, input int n);
    int r;
    int per;
    per = we ? 3 : 3 + LAT;
    drive(0, 1'b1, we, a0, d0);
    drive(1, 1'b1, we, a1, d1);
    @(negedge clk);
    r = cyc;
    reset_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k % 2 == 0) push(0, we, a0, d0, r + k * per + per - 1);
      else            push(1, we, a1, d1, r + k * per + per - 1);
    end
    wait_drain();
    set_req(0, 1'b0);
    set_req(1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = '0;
      d3_arr[i]  = '0;
    end
    for (int i = 0; i < 4; i++) begin
      rd_pipe[i] = '0;
      d3_pipe[i] = '0;
    end
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    d3_req = 1'b0; d3_we = 1'b0; d3_addr = '0; d3_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {p0_gnt, p0_ack, p0_err, p1_gnt, p1_ack, p1_err, mem_RE, mem_WE, busy}, 0);
    check("reset_bus", {mem_addr, mem_data_in}, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_d3", {d3_busy, d3_RE, d3_WE, d3_gnt, d3_ack}, 0);

    // Both ports requesting from reset: 0,1,0,1 at one write per 3 cycles.
    contend(1'b1, 32'h40, 32'h1111_1111, 32'h80, 32'h2222_2222, 4);

    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h10, 32'h0);
    txn(1, 1'b1, 32'h20, 32'hCAFE_F00D);
    txn(1, 1'b0, 32'h20, 32'h0);
    txn(1, 1'b0, 32'h22, 32'h0);
    txn(0, 1'b1, 32'h81, 32'h1234_5678);
    txn(1, 1'b0, 32'h40, 32'h0);

    // p0 raises req during p1's ACCESS; it must wait for the IDLE after p1's ack.
    @(posedge clk); #1;
    c = cyc;
    drive(1, 1'b1, 1'b1, 32'h30, 32'h5A5A_5A5A);
    push(1, 1'b1, 32'h30, 32'h5A5A_5A5A, c + 2);
    @(negedge clk);
    @(negedge clk);
    check("late_p1_gnt", p1_gnt, 1);
    set_req(1, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h30, 32'h0);
    push(0, 1'b0, 32'h30, 32'h0, c + 5 + LAT);
    @(negedge clk);
    check("late_p0_gnt_c2", p0_gnt, 0);
    @(negedge clk);
    check("late_p0_gnt_c3", p0_gnt, 0);
    @(negedge clk);
    check("late_p0_gnt_c4", p0_gnt, 1);
    set_req(0, 1'b0);
    wait_drain();

    // Reset in the WAIT state of a p0 read: nothing acks, then port 0 wins again.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    @(negedge clk);
    set_req(0, 1'b0);
    @(negedge clk);
    check("wait_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_ctl", {busy, mem_RE, mem_WE, p0_ack, p0_err, p1_ack}, 0);
    check("async_rst_rdata", rsp_rdata, 0);
    rdata_model = '0;
    @(negedge clk);
    contend(1'b0, 32'h10, 32'h0, 32'h30, 32'h0, 2);

    // Latency-3 instance: write then read, ack exactly 5 cycles after sampling.
    @(posedge clk); #1;
    d3_req = 1'b1; d3_we = 1'b1; d3_addr = 32'h10; d3_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    check("d3_wr_WE", {d3_WE, d3_gnt}, 2'b11);
    d3_req = 1'b0;
    @(negedge clk);
    check("d3_wr_ack", {d3_ack, d3_err}, 2'b10);
    @(posedge clk); #1;
    d3_req = 1'b1; d3_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("d3_rd_RE", {d3_RE, d3_WE}, 2'b10);
    d3_req = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("d3_ack_c%0d", k), d3_ack, (k == 5) ? 1'b1 : 1'b0);
    end
    check("d3_rdata", d3_rdata, 32'hDEAD_BEEF);

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
